// File: rtl/req_ack_serializer_pkg.sv
// Shared definitions for the req/ack word serializer.
//  - 3-bit FSM state encoding for the frame sequencer
//  - default geometry and the frame-length helper
package req_ack_serializer_pkg;

  // Raw 3-bit state codes
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_START  = S_START,
    ST_DATA   = S_DATA,
    ST_PARITY = S_PARITY,
    ST_STOP   = S_STOP
  } ser_state_e;

  localparam int DW_DEF  = 16;
  localparam int DIV_DEF = 4;

  // Cycles from the first start-bit cycle to the last stop-bit cycle:
  // start + DW data + parity + stop, each DIV cycles long.
  function automatic int frame_cyc(input int dw, input int div);
    return (dw + 3) * div;
  endfunction

endpackage

// File: rtl/req_ack_serializer_baud_tick_gen.sv
// Bit-period tick generator.
//  clk, rstn : clock, async active-low reset
//  clr       : synchronous restart of the period (count back to 0)
//  tick      : high in the last cycle of each DIV-cycle bit period
//  tick_nxt  : tick will be high in the following cycle; lets the
//              sequencer register outputs one cycle ahead of a boundary
// With DIV=1 the counter never leaves 0, so tick is high every cycle.
module baud_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick,
  output logic tick_nxt
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign tick = (cnt == LAST);

  always_comb begin
    cnt_nxt = cnt + CW'(1);
    if (clr || tick) cnt_nxt = '0;
  end

  assign tick_nxt = (cnt_nxt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt <= '0;
    else       cnt <= cnt_nxt;
  end

endmodule

// File: rtl/req_ack_serializer.sv
// req/ack word consumer that shifts each word out as a serial frame:
//   start(0), DW data bits LSB-first, even parity, stop(1); DIV clk per bit.
// A one-word holding buffer sits in front of the shifter, so the next word
// can be accepted while a frame is on the line and frames run back-to-back.
// Ports:
//  clk, rstn  : clock, async active-low reset (drops any frame in flight)
//  d_in       : word offered by upstream
//  req_in     : d_in is valid
//  ack_in     : buffer empty; a word moves on req_in & ack_in at posedge
//  ser_out    : serial line, idles high
//  busy       : a frame is in progress
//  frame_done : one-cycle pulse in the last cycle of each stop bit
module req_ack_serializer
  import req_ack_serializer_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int DIV = DIV_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] d_in,
  input  logic          req_in,
  output logic          ack_in,
  output logic          ser_out,
  output logic          busy,
  output logic          frame_done
);

  localparam int BW = $clog2(DW);

  ser_state_e     state;
  logic [DW-1:0]  hold_q;      // holding buffer
  logic           hold_vld;
  logic [DW-1:0]  shreg;
  logic           parity;
  logic [BW-1:0]  bit_cnt;

  logic tick;
  logic tick_nxt;
  logic clr;
  logic load;

  // Buffer -> shifter move: from IDLE at once, or at the end of a stop bit
  // so the next start bit follows without an idle gap.
  assign load = hold_vld && ((state == ST_IDLE) || (state == ST_STOP && tick));
  // Only a frame started from IDLE needs the bit period realigned; a
  // back-to-back frame is already aligned by the wrap at the stop boundary.
  assign clr  = (state == ST_IDLE) && hold_vld;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr),
    .tick     (tick),
    .tick_nxt (tick_nxt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      hold_q     <= '0;
      hold_vld   <= 1'b0;
      ack_in     <= 1'b1;
      shreg      <= '0;
      parity     <= 1'b0;
      bit_cnt    <= '0;
      ser_out    <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // Holding buffer. ack_in is kept as the registered complement of
      // hold_vld; load needs a full buffer and accept an empty one, so the
      // two never coincide and an offer on a load edge simply waits.
      if (load) begin
        hold_vld <= 1'b0;
        ack_in   <= 1'b1;
      end else if (req_in && ack_in) begin
        hold_q   <= d_in;
        hold_vld <= 1'b1;
        ack_in   <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (hold_vld) begin
            state   <= ST_START;
            shreg   <= hold_q;
            parity  <= ^hold_q;
            ser_out <= 1'b0;
            busy    <= 1'b1;
          end
        end

        ST_START: begin
          if (tick) begin
            state   <= ST_DATA;
            bit_cnt <= BW'(DW - 1);
            ser_out <= shreg[0];
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == '0) begin
              state   <= ST_PARITY;
              ser_out <= parity;
            end else begin
              // line shows the bit that becomes shreg[0] after the shift
              shreg   <= shreg >> 1;
              ser_out <= shreg[1];
              bit_cnt <= bit_cnt - BW'(1);
            end
          end
        end

        ST_PARITY: begin
          if (tick) begin
            state      <= ST_STOP;
            ser_out    <= 1'b1;
            // DIV=1: the single stop cycle is also the last one
            frame_done <= tick_nxt;
          end
        end

        ST_STOP: begin
          if (tick) begin
            if (hold_vld) begin
              state   <= ST_START;
              shreg   <= hold_q;
              parity  <= ^hold_q;
              ser_out <= 1'b0;
            end else begin
              state   <= ST_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            // registered one cycle early so the pulse lands on the last stop cycle
            frame_done <= tick_nxt;
          end
        end

        default: begin
          state   <= ST_IDLE;
          ser_out <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_ack_serializer.sv
module tb_req_ack_serializer;

  localparam int F16 = (16 + 3) * 4;
  localparam int F8  = (8 + 3) * 1;

  typedef struct {
    logic [15:0] word;
    int          edge_no;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] d16;
  logic        req16, ack16, ser16, busy16, fd16;
  logic [7:0]  d8;
  logic        req8, ack8, ser8, busy8, fd8;

  always #5 clk = ~clk;

  req_ack_serializer #(.DW(16), .DIV(4)) dut16 (
    .clk(clk), .rstn(rstn), .d_in(d16), .req_in(req16), .ack_in(ack16),
    .ser_out(ser16), .busy(busy16), .frame_done(fd16)
  );

  req_ack_serializer #(.DW(8), .DIV(1)) dut8 (
    .clk(clk), .rstn(rstn), .d_in(d8), .req_in(req8), .ack_in(ack8),
    .ser_out(ser8), .busy(busy8), .frame_done(fd8)
  );

  int   n_vec  = 0;
  int   n_fail = 0;
  int   ecnt   = 0;
  bit   mon_on = 1'b0;

  // reference model: buffer occupancy + time the line becomes free
  bit          m_bv  [2];
  logic [15:0] m_buf [2];
  int          m_end [2];
  int          n_acc [2];
  int          frames[2];
  exp_t        q0[$];
  exp_t        q1[$];
  int          starts16[$];
  int          fds16[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_fail++;
    $display("FAIL %s (edge %0d)", nm, ecnt);
  endtask

  function automatic logic ser_of(input int i);
    return (i == 1) ? ser8 : ser16;
  endfunction

  function automatic logic fd_of(input int i);
    return (i == 1) ? fd8 : fd16;
  endfunction

  // One clock edge of the reference: a waiting word goes out as soon as the
  // line is free; otherwise an empty buffer takes the offer.
  task automatic model_edge(input int i, input logic r, input logic [15:0] d);
    exp_t e;
    int   f;
    f = (i == 1) ? F8 : F16;
    if (m_bv[i] && ecnt >= m_end[i]) begin
      e.word    = m_buf[i];
      e.edge_no = ecnt;
      if (i == 0) q0.push_back(e); else q1.push_back(e);
      m_end[i] = ecnt + f;
      m_bv[i]  = 1'b0;
    end else if (!m_bv[i] && r) begin
      m_bv[i]  = 1'b1;
      m_buf[i] = d;
      n_acc[i]++;
    end
  endtask

  task automatic cyc(input logic r0, input logic [15:0] w0, input logic r1, input logic [7:0] w1);
    req16 = r0; d16 = w0; req8 = r1; d8 = w1;
    @(posedge clk);
    ecnt++;
    model_edge(0, r0, w0);
    model_edge(1, r1, {8'h00, w1});
    @(negedge clk);
    chk("ack16",  32'(ack16),  32'(!m_bv[0]));
    chk("busy16", 32'(busy16), 32'(ecnt < m_end[0]));
    if (ecnt >= m_end[0]) chk("idle_line16", 32'(ser16), 32'd1);
    chk("ack8",   32'(ack8),   32'(!m_bv[1]));
    chk("busy8",  32'(busy8),  32'(ecnt < m_end[1]));
    if (ecnt >= m_end[1]) chk("idle_line8", 32'(ser8), 32'd1);
  endtask

  // Called at a negedge; reset drops mid-cycle so any response is asynchronous.
  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    chk("rst_ser16",  32'(ser16),  32'd1);
    chk("rst_ack16",  32'(ack16),  32'd1);
    chk("rst_busy16", 32'(busy16), 32'd0);
    chk("rst_fd16",   32'(fd16),   32'd0);
    chk("rst_ser8",   32'(ser8),   32'd1);
    chk("rst_ack8",   32'(ack8),   32'd1);
    for (int i = 0; i < 2; i++) begin
      m_bv[i]  = 1'b0;
      m_end[i] = 0;
    end
    q0.delete();
    q1.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Serial decoder: every frame is checked cycle by cycle for timing,
  // bit stability, frame_done placement, data, parity and stop.
  task automatic monitor(input int i);
    int          dw, div, f;
    logic        s [0:127];
    logic [15:0] w;
    exp_t        e;
    bit          abort, stable;
    dw  = (i == 1) ? 8 : 16;
    div = (i == 1) ? 1 : 4;
    f   = (dw + 3) * div;
    forever begin
      @(negedge clk);
      if (!mon_on || !rstn) continue;
      if (ser_of(i) !== 1'b0) begin
        chk((i == 1) ? "fd_idle8" : "fd_idle16", 32'(fd_of(i)), 32'd0);
        continue;
      end
      if (i == 0 && q0.size() > 0)      e = q0.pop_front();
      else if (i == 1 && q1.size() > 0) e = q1.pop_front();
      else begin
        fail((i == 1) ? "unexpected_frame8" : "unexpected_frame16");
        e.word = 16'h0; e.edge_no = -1;
      end
      chk((i == 1) ? "start_edge8" : "start_edge16", 32'(ecnt), 32'(e.edge_no));
      if (i == 0) starts16.push_back(ecnt);
      s[0]  = ser_of(i);
      abort = 1'b0;
      for (int k = 1; k < f; k++) begin
        @(negedge clk);
        if (!rstn) begin abort = 1'b1; break; end
        s[k] = ser_of(i);
        chk((i == 1) ? "frame_done8" : "frame_done16", 32'(fd_of(i)), 32'(k == f - 1));
        if (i == 0 && fd_of(i) === 1'b1) fds16.push_back(ecnt);
      end
      if (abort) continue;
      stable = 1'b1;
      for (int b = 0; b < dw + 3; b++)
        for (int j = 0; j < div; j++)
          if (s[b*div+j] !== s[b*div]) stable = 1'b0;
      w = '0;
      for (int b = 0; b < dw; b++) w[b] = s[(b+1)*div];
      chk("bit_hold", 32'(stable),         32'd1);
      chk("word",     32'(w),              32'(e.word));
      chk("parity",   32'(s[(dw+1)*div]),  32'(^e.word));
      chk("stop",     32'(s[(dw+2)*div]),  32'd1);
      frames[i]++;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && (m_bv[0] || m_bv[1] || ecnt < m_end[0] + 2 || ecnt < m_end[1] + 2); n++)
      cyc(1'b0, 16'h0, 1'b0, 8'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor(0);
      monitor(1);
    join_none
  end

  initial begin
    int          f0, a0, idx, acc_lo;
    logic [15:0] w3 [3];
    rstn = 1'b1; req16 = 1'b0; d16 = '0; req8 = 1'b0; d8 = '0;
    for (int i = 0; i < 2; i++) begin
      m_bv[i] = 1'b0; m_buf[i] = '0; m_end[i] = 0; n_acc[i] = 0; frames[i] = 0;
    end
    @(negedge clk);
    do_reset();
    mon_on = 1'b1;

    // 1: idle after reset
    for (int n = 0; n < 20; n++) cyc(1'b0, 16'($urandom), 1'b0, 8'($urandom));
    chk("t1_no_frames", 32'(frames[0] + frames[1]), 32'd0);

    // 2: single word, one frame, one frame_done
    f0 = frames[0];
    fds16.delete();
    cyc(1'b1, 16'hA5C3, 1'b0, 8'h0);
    drain();
    chk("t2_frames", 32'(frames[0] - f0), 32'd1);
    chk("t2_fd_cnt", 32'(fds16.size()), 32'd1);

    // 3: req held high, three words, back-to-back frames
    w3[0] = 16'h0001; w3[1] = 16'h8000; w3[2] = 16'hFFFF;
    starts16.delete();
    fds16.delete();
    idx = 0;
    for (int n = 0; n < 400 && idx < 3; n++) begin
      a0 = n_acc[0];
      cyc(1'b1, w3[idx], 1'b0, 8'h0);
      if (n_acc[0] != a0) idx++;
    end
    chk("t3_accepted", 32'(idx), 32'd3);
    drain();
    if (starts16.size() >= 3 && fds16.size() >= 3) begin
      chk("t3_span",   32'(fds16[2] - starts16[0] + 1), 32'd228);
      chk("t3_b2b_1",  32'(starts16[1]), 32'(fds16[0] + 1));
      chk("t3_b2b_2",  32'(starts16[2]), 32'(fds16[1] + 1));
    end else fail("t3_frame_count");

    // 4: random traffic on both instances
    f0 = frames[0];
    acc_lo = 0;
    for (int n = 0; n < 4500; n++) begin
      cyc(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
      if (m_bv[0]) acc_lo++;
    end
    drain();
    chk("t4_words_ge50", 32'(frames[0] - f0 >= 50), 32'd1);
    chk("t4_ack_low_ge5", 32'(acc_lo >= 5), 32'd1);
    chk("t4_q16_empty", 32'(q0.size()), 32'd0);
    chk("t4_q8_empty",  32'(q1.size()), 32'd0);

    // 5: reset during data bit 7, with a second word waiting in the buffer
    cyc(1'b1, 16'h0F0F, 1'b0, 8'h0);
    cyc(1'b0, 16'h0, 1'b0, 8'h0);
    cyc(1'b1, 16'hAAAA, 1'b0, 8'h0);
    for (int n = 0; n < 32; n++) cyc(1'b0, 16'h0, 1'b0, 8'h0);
    chk("t5_bit7", 32'(ser16), 32'd0);
    chk("t5_ack_low", 32'(ack16), 32'd0);
    do_reset();
    f0 = frames[0];
    cyc(1'b1, 16'h1234, 1'b0, 8'h0);
    drain();
    chk("t5_frames", 32'(frames[0] - f0), 32'd1);

    // 6: DW=8, DIV=1, 11-cycle frame
    f0 = frames[1];
    cyc(1'b0, 16'h0, 1'b1, 8'hFF);
    drain();
    chk("t6_frames", 32'(frames[1] - f0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
